// File: rtl/inst_seq_mem.sv
// Instruction memory and sequencer for a PE: appends broadcast instructions into a
// block-RAM program store, then replays the stored program through a program counter.
module inst_seq_mem #(
    parameter int INST_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 6,
    parameter int LOOP_WIDTH   = 8,
    parameter int LAUNCH_DELAY = 16,
    parameter int AUTO_START   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_in_v,
    input  logic [INST_WIDTH-1:0] inst_in,
    input  logic                  start,
    input  logic [LOOP_WIDTH-1:0] loop_cnt,
    output logic                  inst_out_v,
    output logic [INST_WIDTH-1:0] inst_out,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH:0]   prog_len,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int GAP_W = $clog2(LAUNCH_DELAY + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_ONE    = ADDR_WIDTH'(1);
    localparam logic [PTR_W-1:0]      PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]      PTR_DEPTH = PTR_W'(DEPTH);
    localparam logic [GAP_W-1:0]      GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0]      GAP_MAX   = GAP_W'(LAUNCH_DELAY);
    localparam logic [GAP_W-1:0]      GAP_FIRE  = GAP_W'(LAUNCH_DELAY - 1);
    localparam logic [LOOP_WIDTH-1:0] ITER_ONE  = LOOP_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      prog_len_q, prog_len_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [LOOP_WIDTH-1:0] iter_q, iter_d;
    logic [LOOP_WIDTH-1:0] loop_q, loop_d;
    logic [INST_WIDTH-1:0] inst_out_q, inst_out_d;
    logic                  inst_out_v_q, inst_out_v_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_waddr;
    logic                  launch;
    logic                  last_addr;

    logic [INST_WIDTH-1:0] imem [DEPTH];

    assign last_addr = ({1'b0, pc_q} == (prog_len_q - PTR_ONE));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        prog_len_d   = prog_len_q;
        pc_d         = pc_q;
        gap_d        = gap_q;
        iter_d       = iter_q;
        loop_d       = loop_q;
        inst_out_d   = inst_out_q;
        inst_out_v_d = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        imem_we      = 1'b0;
        imem_waddr   = wr_ptr_q[ADDR_WIDTH-1:0];
        launch       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (inst_in_v) begin
                    // A write while idle always begins a fresh program at address 0
                    imem_we    = 1'b1;
                    imem_waddr = '0;
                    wr_ptr_d   = PTR_ONE;
                    gap_d      = '0;
                    prog_len_d = '0;
                    state_d    = S_LOAD;
                end else if (start && (prog_len_q != '0)) begin
                    launch = 1'b1;
                end
            end

            S_LOAD: begin
                if (inst_in_v) begin
                    gap_d = '0;
                    if (wr_ptr_q == PTR_DEPTH) begin
                        err_d = 1'b1;
                    end else begin
                        imem_we  = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_ONE;
                    end
                end else begin
                    if (gap_q != GAP_MAX) begin
                        gap_d = gap_q + GAP_ONE;
                    end
                    if (AUTO_START != 0) begin
                        if (gap_q == GAP_FIRE) begin
                            launch     = 1'b1;
                            prog_len_d = wr_ptr_q;
                        end
                    end else if (start) begin
                        launch     = 1'b1;
                        prog_len_d = wr_ptr_q;
                    end
                end
            end

            S_RUN: begin
                if (inst_in_v) begin
                    err_d = 1'b1;
                end
                inst_out_d   = imem[pc_q];
                inst_out_v_d = 1'b1;
                if (last_addr) begin
                    if (iter_q == loop_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        pc_d   = '0;
                        iter_d = iter_q + ITER_ONE;
                    end
                end else begin
                    pc_d = pc_q + PC_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (launch) begin
            state_d = S_RUN;
            pc_d    = '0;
            iter_d  = '0;
            loop_d  = loop_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            pc_q         <= '0;
            gap_q        <= '0;
            iter_q       <= '0;
            loop_q       <= '0;
            inst_out_q   <= '0;
            inst_out_v_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            prog_len_q   <= prog_len_d;
            pc_q         <= pc_d;
            gap_q        <= gap_d;
            iter_q       <= iter_d;
            loop_q       <= loop_d;
            inst_out_q   <= inst_out_d;
            inst_out_v_q <= inst_out_v_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Program store has no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= inst_in;
        end
    end

    assign inst_out_v = inst_out_v_q;
    assign inst_out   = inst_out_q;
    assign pc         = pc_q;
    assign prog_len   = prog_len_q;
    assign busy       = (state_q == S_RUN) || inst_out_v_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_inst_seq_mem.sv
// Scoreboard bench for inst_seq_mem: one auto-start and one manual-start instance, each
// checked against a queue-based program model built from the load/run rules.
module tb_inst_seq_mem;

    localparam int IW    = 64;
    localparam int AW    = 3;
    localparam int LW    = 8;
    localparam int DEPTH = 8;
    localparam int LD0   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          in_v   [2];
    logic [IW-1:0] in_d   [2];
    logic          st     [2];
    logic [LW-1:0] lc     [2];
    logic          out_v  [2];
    logic [IW-1:0] out_d  [2];
    logic [AW-1:0] pc_o   [2];
    logic [AW:0]   plen   [2];
    logic          busy_o [2];
    logic          done_o [2];
    logic          err_o  [2];

    inst_seq_mem #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .LOOP_WIDTH(LW),
                   .LAUNCH_DELAY(LD0), .AUTO_START(1)) dut_auto (
        .clk(clk), .rst_n(rst_n), .inst_in_v(in_v[0]), .inst_in(in_d[0]),
        .start(st[0]), .loop_cnt(lc[0]), .inst_out_v(out_v[0]), .inst_out(out_d[0]),
        .pc(pc_o[0]), .prog_len(plen[0]), .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
    );

    inst_seq_mem #(.INST_WIDTH(IW), .ADDR_WIDTH(AW), .LOOP_WIDTH(LW),
                   .LAUNCH_DELAY(4), .AUTO_START(0)) dut_man (
        .clk(clk), .rst_n(rst_n), .inst_in_v(in_v[1]), .inst_in(in_d[1]),
        .start(st[1]), .loop_cnt(lc[1]), .inst_out_v(out_v[1]), .inst_out(out_d[1]),
        .pc(pc_o[1]), .prog_len(plen[1]), .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
    );

    typedef struct {
        int          dut;
        logic [IW-1:0] data;
        bit          last;
        int          when;
    } exp_t;

    exp_t          exp_q[$];
    logic [IW-1:0] mdl_prog[$];
    bit            mdl_err [2];
    int checks = 0;
    int failures = 0;
    int seen = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Drives one cycle of inputs on instance k; called and returns 1 time unit after a rising edge
    task automatic applyStimulus(input int k, input logic v, input logic [IW-1:0] d, input logic s);
        in_v[k] = v;
        in_d[k] = d;
        st[k]   = s;
        @(posedge clk);
        #1;
        in_v[k] = 1'b0;
        st[k]   = 1'b0;
    endtask

    task automatic idle(input int k, input int n);
        for (int i = 0; i < n; i++) applyStimulus(k, 1'b0, '0, 1'b0);
    endtask

    // Appends n words; words beyond DEPTH are dropped by the model and flag an error
    task automatic loadProg(input int k, input int n, input bit fixed, input int max_gap,
                            output int last_wr);
        logic [IW-1:0] w;
        mdl_prog.delete();
        last_wr = cyc;
        for (int i = 0; i < n; i++) begin
            if (i > 0 && max_gap > 0) idle(k, $urandom_range(0, max_gap));
            w = fixed ? IW'(64'h11 + 64'(i)) : {$urandom, $urandom};
            last_wr = cyc;
            applyStimulus(k, 1'b1, w, 1'b0);
            if (mdl_prog.size() < DEPTH) mdl_prog.push_back(w);
            else mdl_err[k] = 1'b1;
        end
    endtask

    task automatic pushRun(input int k, input int first, input int loops);
        exp_t e;
        int len = mdl_prog.size();
        for (int p = 0; p <= loops; p++) begin
            for (int i = 0; i < len; i++) begin
                e.dut  = k;
                e.data = mdl_prog[i];
                e.last = (p == loops) && (i == len - 1);
                e.when = first + p * len + i;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drainAndCheck(input int k);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) idle(k, 1);
        checkOutput("drain_remaining", 64'(exp_q.size()), 0);
        exp_q.delete();
        idle(k, 1);
        checkOutput("busy_after_run", 64'(busy_o[k]), 0);
        checkOutput("done_after_run", 64'(done_o[k]), 0);
        checkOutput("prog_len", 64'(plen[k]), 64'(mdl_prog.size()));
        checkOutput("err", 64'(err_o[k]), 64'(mdl_err[k]));
    endtask

    task automatic startRun(input int k, input int loops);
        int s;
        lc[k] = LW'(loops);
        s = cyc;
        applyStimulus(k, 1'b0, '0, 1'b1);
        pushRun(k, s + 2, loops);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (done_o[k] && !out_v[k]) checkOutput("done_without_valid", 64'(done_o[k]), 0);
                if (out_v[k]) begin
                    seen++;
                    if (exp_q.size() == 0 || exp_q[0].dut != k) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpected_valid dut=%0d cycle=%0d actual=0x%0h required=no output",
                                 k, cyc, out_d[k]);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("inst_out", out_d[k], e.data);
                        checkOutput("valid_cycle", 64'(cyc), 64'(e.when));
                        checkOutput("done_flag", 64'(done_o[k]), 64'(e.last));
                        checkOutput("busy_with_valid", 64'(busy_o[k]), 1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lw;
        int base;
        int n;
        int loops;
        for (int k = 0; k < 2; k++) begin
            in_v[k] = 1'b0; in_d[k] = '0; st[k] = 1'b0; lc[k] = '0; mdl_err[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_valid", 64'(out_v[k]), 0);
            checkOutput("reset_inst_out", out_d[k], 0);
            checkOutput("reset_pc", 64'(pc_o[k]), 0);
            checkOutput("reset_prog_len", 64'(plen[k]), 0);
            checkOutput("reset_busy", 64'(busy_o[k]), 0);
            checkOutput("reset_err", 64'(err_o[k]), 0);
        end
        rst_n = 1'b1;
        idle(0, 2);

        // Auto start: 0x11..0x15, first output LAUNCH_DELAY+2 cycles after the last write
        $display("[TB] auto-start fixed program");
        lc[0] = '0;
        loadProg(0, 5, 1'b1, 0, lw);
        pushRun(0, lw + LD0 + 2, 0);
        drainAndCheck(0);

        $display("[TB] replay with loop_cnt=2 and 0");
        startRun(0, 2);
        drainAndCheck(0);
        startRun(0, 0);
        drainAndCheck(0);

        $display("[TB] randomized auto-start programs");
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, DEPTH);
            loops = $urandom_range(0, 3);
            lc[0] = LW'(loops);
            loadProg(0, n, 1'b0, 3, lw);
            pushRun(0, lw + LD0 + 2, loops);
            drainAndCheck(0);
            startRun(0, $urandom_range(0, 2));
            drainAndCheck(0);
        end

        $display("[TB] write during run sets err and is ignored");
        startRun(0, 1);
        applyStimulus(0, 1'b1, {$urandom, $urandom}, 1'b0);
        mdl_err[0] = 1'b1;
        drainAndCheck(0);

        $display("[TB] overflow load");
        lc[0] = '0;
        loadProg(0, DEPTH + 2, 1'b0, 0, lw);
        pushRun(0, lw + LD0 + 2, 0);
        drainAndCheck(0);

        $display("[TB] reset during run");
        base = seen;
        startRun(0, 0);
        for (int i = 0; i < 40 && seen < base + 3; i++) begin
            @(negedge clk);
            #1;
        end
        checkOutput("reached_third_output", 64'(seen - base), 3);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 64'(out_v[0]), 0);
        checkOutput("abort_busy", 64'(busy_o[0]), 0);
        checkOutput("abort_prog_len", 64'(plen[0]), 0);
        exp_q.delete();
        mdl_prog.delete();
        mdl_err[0] = 1'b0;
        mdl_err[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 2);
        applyStimulus(0, 1'b0, '0, 1'b1);
        idle(0, 20);
        checkOutput("start_without_program_busy", 64'(busy_o[0]), 0);
        checkOutput("start_without_program_len", 64'(plen[0]), 0);

        $display("[TB] manual start instance");
        applyStimulus(1, 1'b0, '0, 1'b1);
        idle(1, 10);
        checkOutput("manual_empty_start_busy", 64'(busy_o[1]), 0);
        loadProg(1, 3, 1'b0, 10, lw);
        idle(1, 100);
        checkOutput("manual_no_autostart", 64'(busy_o[1]), 0);
        startRun(1, $urandom_range(0, 2));
        drainAndCheck(1);

        loadProg(1, 2, 1'b0, 0, lw);
        idle(1, 2);
        begin
            logic [IW-1:0] w;
            w = {$urandom, $urandom};
            applyStimulus(1, 1'b1, w, 1'b1);
            mdl_prog.push_back(w);
        end
        idle(1, 30);
        checkOutput("start_with_write_no_run", 64'(busy_o[1]), 0);
        startRun(1, 0);
        drainAndCheck(1);

        for (int t = 0; t < 3; t++) begin
            loadProg(1, $urandom_range(1, DEPTH + 3), 1'b0, 8, lw);
            idle(1, $urandom_range(1, 20));
            startRun(1, $urandom_range(0, 3));
            drainAndCheck(1);
            startRun(1, $urandom_range(0, 1));
            drainAndCheck(1);
        end

        checkOutput("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_seq_mem.md
Name: inst_seq_mem

Overview:
- Parametrised instruction memory and sequencer for a PE: one block-RAM program store, a load phase that appends incoming instructions, and a run phase that replays the stored program through a program counter.
- Adds over the previous generation:
  - explicit FSM;
  - programmable launch delay;
  - auto or manual start;
  - loop repeat count;
  - replay without reload;
  - overflow/error reporting.
- Sits between the array's instruction broadcast bus and the PE decode stage.

Parameters:
INST_WIDTH, 64, instruction word width
ADDR_WIDTH, 6, IMEM address width; DEPTH = 2**ADDR_WIDTH
LOOP_WIDTH, 8, width of loop_cnt
LAUNCH_DELAY, 16, consecutive idle load cycles before auto-start (>=1)
AUTO_START, 1, 1 = run starts after LAUNCH_DELAY idle cycles; 0 = run starts only on start pulse

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
inst_in_v  in  1  instruction write valid
inst_in  in  INST_WIDTH  instruction word
start  in  1  one-cycle run/replay request
loop_cnt  in  LOOP_WIDTH  extra passes; program executes loop_cnt+1 times
inst_out_v  out  1  inst_out valid
inst_out  out  INST_WIDTH  instruction read from IMEM
pc  out  ADDR_WIDTH  current read address
prog_len  out  ADDR_WIDTH+1  number of stored instructions
busy  out  1  run in progress
done  out  1  one-cycle pulse with final inst_out_v
err  out  1  sticky: write beyond DEPTH or inst_in_v during RUN

Behaviour:
- Single clock domain.
- Reset (rst_n low, asynchronous):
  - FSM to IDLE.
  - pc, prog_len, gap counter, iteration counter = 0.
  - inst_out = 0; inst_out_v, busy, done, err = 0.
  - IMEM array is not cleared.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - inst_in_v=1: write imem[0], wr_ptr=1, go to LOAD (starts a new program; prior program discarded).
  - Else start=1 and prog_len!=0: go to RUN.
  - Start with prog_len=0 is ignored.
- LOAD:
  - Each inst_in_v=1 cycle writes imem[wr_ptr], wr_ptr++, and clears the gap counter.
  - inst_in_v=0 increments the gap counter.
  - wr_ptr==DEPTH with inst_in_v=1: word dropped, err set, wr_ptr holds.
  - AUTO_START=1: when the gap counter reaches LAUNCH_DELAY, prog_len<=wr_ptr and go to RUN on that edge.
  - AUTO_START=0: start=1 with inst_in_v=0 sets prog_len<=wr_ptr and goes to RUN. start coincident with inst_in_v=1 is ignored (write wins).
- RUN:
  - Entry samples loop_cnt into an internal register; pc=0, iter=0.
  - One synchronous read per cycle at pc.
  - pc==prog_len-1 and iter<loop_cnt_reg: pc<=0, iter++ (no bubble at wrap).
  - pc==prog_len-1 and iter==loop_cnt_reg: go to IDLE; prog_len retained for replay.
  - inst_in_v during RUN: word ignored, err set.
  - start during RUN is ignored.
- Read latency 1 cycle: inst_out/inst_out_v registered; inst_out_v is high in the cycle after each RUN read.
- Valid words are contiguous: exactly prog_len*(loop_cnt+1) consecutive inst_out_v cycles.
- done: high together with the final inst_out_v only.
- busy: high from the first RUN cycle through the cycle of the final inst_out_v.
- Reset mid-RUN or mid-LOAD: immediate abort; no further inst_out_v; prog_len=0, so a reload is required.
- Arithmetic: pc/wr_ptr wrap is impossible by construction (wr_ptr saturates at DEPTH; pc < prog_len).
- err cleared only by reset.

Test Plan:
- AUTO_START=1, LAUNCH_DELAY=16, load 5 words (0x11..0x15) cycles 0-4, loop_cnt=0 -> RUN entered at edge ending cycle 20; inst_out_v cycles 22-26 carrying 0x11..0x15; done at cycle 26; prog_len=5; err=0.
- Same program, loop_cnt=2 -> 15 contiguous valids with sequence 0x11..0x15 repeated 3 times; done only on 15th; busy drops after.
- After completion, start pulse in IDLE at cycle S -> replay: inst_out_v S+2..S+6 with 0x11..0x15, no reload.
- AUTO_START=0, load 3 words, gap of 100 cycles -> no output; start at cycle S -> outputs S+2..S+4; start asserted together with inst_in_v -> word appended, no run.
- ADDR_WIDTH=2: load 6 words -> prog_len=4, err=1, run outputs first 4 words only.
- rst_n low at the 3rd output of a 5-word run -> inst_out_v=0 and busy=0 immediately; prog_len=0; subsequent start ignored until reload.
